// File: rtl/ddr3_init_pkg.sv
// Shared constants and types for the DDR3 hardware init sequencer.
// Holds the DFII CSR map, control/command bit definitions, mode register
// values, FSM state encodings and the step record used by the step ROM.
package ddr3_init_pkg;

    // DFII CSR word offsets relative to DFII_CONTROL
    localparam logic [2:0] OFF_CONTROL  = 3'd0;
    localparam logic [2:0] OFF_COMMAND  = 3'd1;
    localparam logic [2:0] OFF_ISSUE    = 3'd2;
    localparam logic [2:0] OFF_ADDRESS  = 3'd3;
    localparam logic [2:0] OFF_BADDRESS = 3'd4;

    // DFII_CONTROL bits
    localparam logic [31:0] CTRL_SEL     = 32'h01;
    localparam logic [31:0] CTRL_CKE     = 32'h02;
    localparam logic [31:0] CTRL_ODT     = 32'h04;
    localparam logic [31:0] CTRL_RESET_N = 32'h08;

    // DFII_COMMAND bits
    localparam logic [31:0] CMD_CS  = 32'h01;
    localparam logic [31:0] CMD_WE  = 32'h02;
    localparam logic [31:0] CMD_CAS = 32'h04;
    localparam logic [31:0] CMD_RAS = 32'h08;
    localparam logic [31:0] CMD_MRS  = CMD_RAS | CMD_CAS | CMD_WE | CMD_CS;
    localparam logic [31:0] CMD_ZQCL = CMD_WE | CMD_CS;

    // Mode register payloads and banks
    localparam logic [31:0] MR2_VAL        = 32'h200;
    localparam logic [31:0] MR3_VAL        = 32'h000;
    localparam logic [31:0] MR1_VAL        = 32'h006;
    localparam logic [31:0] MR0_DLLRST_VAL = 32'h320;
    localparam logic [31:0] MR0_VAL        = 32'h220;
    localparam logic [31:0] ZQCL_ADDR      = 32'h400;
    localparam logic [31:0] BANK_MR0 = 32'd0;
    localparam logic [31:0] BANK_MR1 = 32'd1;
    localparam logic [31:0] BANK_MR2 = 32'd2;
    localparam logic [31:0] BANK_MR3 = 32'd3;

    // Post-write delay selector
    localparam logic [1:0] DLY_NONE    = 2'd0;
    localparam logic [1:0] DLY_TDLLK   = 2'd1;
    localparam logic [1:0] DLY_TZQINIT = 2'd2;
    localparam logic [1:0] DLY_SETTLE  = 2'd3;

    // Sequencer FSM encodings
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_POR_WAIT = 3'd1;
    localparam state_t ST_WRITE    = 3'd2;
    localparam state_t ST_GAP      = 3'd3;
    localparam state_t ST_DELAY    = 3'd4;
    localparam state_t ST_DONE     = 3'd5;
    localparam state_t ST_ERROR    = 3'd6;

    localparam logic [4:0] LAST_STEP = 5'd28;

    typedef struct packed {
        logic [2:0]  offset;
        logic [31:0] data;
        logic [1:0]  delay_sel;
    } step_t;

    function automatic step_t mk_step(logic [2:0] off, logic [31:0] dat, logic [1:0] dly);
        step_t s;
        s.offset    = off;
        s.data      = dat;
        s.delay_sel = dly;
        return s;
    endfunction

endpackage

// File: rtl/ddr3_init_sequencer_rom.sv
// Step ROM: maps the 5-bit step index to the CSR write (offset, data) and
// the delay to insert after it. Purely combinational.
module ddr3_init_sequencer_rom
    import ddr3_init_pkg::*;
(
    input  logic [4:0] idx_i,
    output step_t      step_o
);

    // Decode the step index into its write record
    always_comb begin
        step_o = mk_step(OFF_ADDRESS, 32'd0, DLY_NONE);
        case (idx_i)
            5'd0:  step_o = mk_step(OFF_ADDRESS,  32'd0, DLY_NONE);
            5'd1:  step_o = mk_step(OFF_BADDRESS, 32'd0, DLY_NONE);
            5'd2:  step_o = mk_step(OFF_CONTROL,  CTRL_ODT | CTRL_RESET_N, DLY_NONE);
            5'd3:  step_o = mk_step(OFF_CONTROL,  CTRL_ODT | CTRL_RESET_N | CTRL_CKE, DLY_NONE);
            // MR2
            5'd4:  step_o = mk_step(OFF_ADDRESS,  MR2_VAL,  DLY_NONE);
            5'd5:  step_o = mk_step(OFF_BADDRESS, BANK_MR2, DLY_NONE);
            5'd6:  step_o = mk_step(OFF_COMMAND,  CMD_MRS,  DLY_NONE);
            5'd7:  step_o = mk_step(OFF_ISSUE,    32'd1,    DLY_NONE);
            // MR3
            5'd8:  step_o = mk_step(OFF_ADDRESS,  MR3_VAL,  DLY_NONE);
            5'd9:  step_o = mk_step(OFF_BADDRESS, BANK_MR3, DLY_NONE);
            5'd10: step_o = mk_step(OFF_COMMAND,  CMD_MRS,  DLY_NONE);
            5'd11: step_o = mk_step(OFF_ISSUE,    32'd1,    DLY_NONE);
            // MR1
            5'd12: step_o = mk_step(OFF_ADDRESS,  MR1_VAL,  DLY_NONE);
            5'd13: step_o = mk_step(OFF_BADDRESS, BANK_MR1, DLY_NONE);
            5'd14: step_o = mk_step(OFF_COMMAND,  CMD_MRS,  DLY_NONE);
            5'd15: step_o = mk_step(OFF_ISSUE,    32'd1,    DLY_NONE);
            // MR0 with DLL reset
            5'd16: step_o = mk_step(OFF_ADDRESS,  MR0_DLLRST_VAL, DLY_NONE);
            5'd17: step_o = mk_step(OFF_BADDRESS, BANK_MR0, DLY_NONE);
            5'd18: step_o = mk_step(OFF_COMMAND,  CMD_MRS,  DLY_NONE);
            5'd19: step_o = mk_step(OFF_ISSUE,    32'd1,    DLY_NONE);
            // MR0 final, then wait for DLL lock
            5'd20: step_o = mk_step(OFF_ADDRESS,  MR0_VAL,  DLY_NONE);
            5'd21: step_o = mk_step(OFF_BADDRESS, BANK_MR0, DLY_NONE);
            5'd22: step_o = mk_step(OFF_COMMAND,  CMD_MRS,  DLY_NONE);
            5'd23: step_o = mk_step(OFF_ISSUE,    32'd1,    DLY_TDLLK);
            // ZQ calibration long, then wait for it to finish
            5'd24: step_o = mk_step(OFF_ADDRESS,  ZQCL_ADDR, DLY_NONE);
            5'd25: step_o = mk_step(OFF_BADDRESS, 32'd0,     DLY_NONE);
            5'd26: step_o = mk_step(OFF_COMMAND,  CMD_ZQCL,  DLY_NONE);
            5'd27: step_o = mk_step(OFF_ISSUE,    32'd1,     DLY_TZQINIT);
            // Hand the PHY back to the hardware controller
            5'd28: step_o = mk_step(OFF_CONTROL,  CTRL_SEL,  DLY_SETTLE);
            default: step_o = mk_step(OFF_ADDRESS, 32'd0, DLY_NONE);
        endcase
    end

endmodule

// File: rtl/ddr3_init_sequencer.sv
// DDR3 bring-up sequencer: Wishbone master that replays the DFII init
// sequence (reset/CKE, MR2/3/1/0, ZQCL, handover) and then raises done.
// Optional macro DDR3_INIT_TIMEOUT_EN adds an ack watchdog and ERROR state.
// All delay parameters must be at least 1.
module ddr3_init_sequencer
    import ddr3_init_pkg::*;
#(
    parameter logic [29:0] CSR_BASE           = 30'h2400,
    parameter int          POR_CYCLES         = 35,
    parameter int          TDLLK_CYCLES       = 600,
    parameter int          TZQINIT_CYCLES     = 600,
    parameter int          SETTLE_CYCLES      = 200,
    parameter int          ACK_TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [29:0] wb_adr,
    output logic [31:0] wb_dat_w,
    output logic [3:0]  wb_sel,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    input  logic        wb_ack
);

    // One counter serves POR, post-write delays and (optionally) the ack
    // watchdog, since those never overlap.
    localparam int MAX_A   = (POR_CYCLES > TDLLK_CYCLES) ? POR_CYCLES : TDLLK_CYCLES;
    localparam int MAX_B   = (TZQINIT_CYCLES > SETTLE_CYCLES) ? TZQINIT_CYCLES : SETTLE_CYCLES;
    localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_DLY = (MAX_C > ACK_TIMEOUT_CYCLES) ? MAX_C : ACK_TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_DLY + 1);

    state_t             state_q, state_d;
    logic [4:0]         step_q, step_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   dly_last;
    step_t              step_rec;
    logic               in_write;

    ddr3_init_sequencer_rom u_rom (
        .idx_i  (step_q),
        .step_o (step_rec)
    );

    // Terminal count for the post-write delay of the current step
    always_comb begin
        case (step_rec.delay_sel)
            DLY_TDLLK:   dly_last = CNT_W'(TDLLK_CYCLES - 1);
            DLY_TZQINIT: dly_last = CNT_W'(TZQINIT_CYCLES - 1);
            DLY_SETTLE:  dly_last = CNT_W'(SETTLE_CYCLES - 1);
            default:     dly_last = '0;
        endcase
    end

    // Sequencer next-state logic
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_POR_WAIT;
                    step_d  = '0;
                    cnt_d   = '0;
                end
            end
            ST_POR_WAIT: begin
                if (cnt_q == CNT_W'(POR_CYCLES - 1)) begin
                    state_d = ST_WRITE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WRITE: begin
                if (wb_ack) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end
`ifdef DDR3_INIT_TIMEOUT_EN
                else if (cnt_q == CNT_W'(ACK_TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_ERROR;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ST_GAP: begin
                if (step_rec.delay_sel != DLY_NONE) begin
                    state_d = ST_DELAY;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_WRITE;
                    step_d  = step_q + 5'd1;
                end
            end
            ST_DELAY: begin
                if (cnt_q == dly_last) begin
                    cnt_d = '0;
                    if (step_q == LAST_STEP) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WRITE;
                        step_d  = step_q + 5'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ; // ST_ERROR is left only by reset
        endcase
    end

    // State, step and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
        end
    end

    // Bus signals decode straight from state so reset drops them at once
    assign in_write = (state_q == ST_WRITE);
    assign wb_cyc   = in_write;
    assign wb_stb   = in_write;
    assign wb_we    = in_write;
    assign wb_sel   = in_write ? 4'hF : 4'h0;
    assign wb_adr   = in_write ? (CSR_BASE + {27'd0, step_rec.offset}) : 30'd0;
    assign wb_dat_w = in_write ? step_rec.data : 32'd0;

    assign busy = (state_q == ST_POR_WAIT) || in_write ||
                  (state_q == ST_GAP) || (state_q == ST_DELAY);
    assign done = (state_q == ST_DONE);
`ifdef DDR3_INIT_TIMEOUT_EN
    assign error = (state_q == ST_ERROR);
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_ddr3_init_sequencer.sv
// Directed bench for ddr3_init_sequencer: full sequence, ack stall,
// ignored starts, restart from DONE, async reset and (with
// DDR3_INIT_TIMEOUT_EN) the ack watchdog.
module tb_ddr3_init_sequencer;

    localparam int POR     = 35;
    localparam int TDLLK   = 600;
    localparam int TZQ     = 600;
    localparam int SETTLE  = 200;
    localparam int ACK_TO  = 256;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        busy, done, error;
    logic [29:0] wb_adr;
    logic [31:0] wb_dat_w;
    logic [3:0]  wb_sel;
    logic        wb_cyc, wb_stb, wb_we;
    logic        wb_ack;

    int checks = 0;
    int errors = 0;

    int cyc_n = 0;
    logic [29:0] wr_adr[$];
    logic [31:0] wr_dat[$];
    int          wr_beg[$];
    int          wr_end[$];
    int          done_at = -1;
    int          unstable = 0;
    int          stall_idx = -1;
    int          stall_left = 0;
    logic        stb_prev, done_prev;

    // Hand-computed write table: CSR offset and data for each of the 29 writes
    int exp_off [29] = '{3,4,0,0, 3,4,1,2, 3,4,1,2, 3,4,1,2, 3,4,1,2, 3,4,1,2, 3,4,1,2, 0};
    int exp_dat [29] = '{0,0,'h0C,'h0E, 'h200,2,'h0F,1, 0,3,'h0F,1, 6,1,'h0F,1,
                         'h320,0,'h0F,1, 'h220,0,'h0F,1, 'h400,0,'h03,1, 1};

    ddr3_init_sequencer #(
        .CSR_BASE           (30'h2400),
        .POR_CYCLES         (POR),
        .TDLLK_CYCLES       (TDLLK),
        .TZQINIT_CYCLES     (TZQ),
        .SETTLE_CYCLES      (SETTLE),
        .ACK_TIMEOUT_CYCLES (ACK_TO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .wb_adr   (wb_adr),
        .wb_dat_w (wb_dat_w),
        .wb_sel   (wb_sel),
        .wb_cyc   (wb_cyc),
        .wb_stb   (wb_stb),
        .wb_we    (wb_we),
        .wb_ack   (wb_ack)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Bus monitor and Wishbone slave, evaluated on the falling edge
    initial begin
        wb_ack    = 1'b0;
        stb_prev  = 1'b0;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (wb_stb && !stb_prev) begin
                wr_adr.push_back(wb_adr);
                wr_dat.push_back(wb_dat_w);
                wr_beg.push_back(cyc_n);
                $display("write %0d: adr 0x%0h dat 0x%0h at cycle %0d",
                         wr_adr.size() - 1, wb_adr, wb_dat_w, cyc_n);
            end else if (wb_stb) begin
                if (wb_adr !== wr_adr[$] || wb_dat_w !== wr_dat[$]) unstable++;
            end
            if (wb_stb && (!wb_cyc || !wb_we || wb_sel !== 4'hF)) unstable++;
            if (!wb_stb && stb_prev) wr_end.push_back(cyc_n);
            if (done && !done_prev) done_at = cyc_n;
            stb_prev  = wb_stb;
            done_prev = done;
            if (wb_cyc && wb_stb && !wb_ack) begin
                if ((wr_adr.size() - 1) == stall_idx && stall_left > 0) stall_left--;
                else wb_ack = 1'b1;
            end else begin
                wb_ack = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic clear_log();
        wr_adr.delete();
        wr_dat.delete();
        wr_beg.delete();
        wr_end.delete();
        done_at = -1;
    endtask

    task automatic wait_writes(input int n, input int limit);
        int k;
        k = 0;
        while (wr_adr.size() < n && k < limit) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        check($sformatf("wait_writes_%0d", n), wr_adr.size() >= n, 1);
    endtask

    task automatic wait_done(input int limit);
        int k;
        k = 0;
        while (!done && k < limit) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        check("wait_done", done, 1);
    endtask

    initial begin
        int t_start;
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_cyc", wb_cyc, 0);
        check("rst_stb", wb_stb, 0);
        check("rst_we", wb_we, 0);
        check("rst_sel", wb_sel, 0);
        check("rst_adr", wb_adr, 0);
        check("rst_dat", wb_dat_w, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        rst_n = 1'b1;

        // Run 1: full sequence with single-cycle ack
        clear_log();
        pulse_start();
        t_start = cyc_n;
        check("run1_busy", busy, 1);
        wait_done(5000);
        check("run1_count", wr_adr.size(), 29);
        for (int i = 0; i < 29; i++) begin
            if (i < wr_adr.size()) begin
                check($sformatf("run1_w%0d_adr", i), wr_adr[i], 30'h2400 + exp_off[i]);
                check($sformatf("run1_w%0d_dat", i), wr_dat[i], exp_dat[i]);
            end
        end
        if (wr_adr.size() == 29) begin
            check("run1_por_latency", wr_beg[0] - t_start, POR);
            check("run1_ack_len", wr_end[0] - wr_beg[0], 1);
            check("run1_gap", wr_beg[1] - wr_end[0], 1);
            check("run1_tdllk", wr_beg[24] - wr_end[23], TDLLK + 1);
            check("run1_tzqinit", wr_beg[28] - wr_end[27], TZQ + 1);
            check("run1_settle", done_at - wr_end[28], SETTLE + 1);
        end
        check("run1_busy_done", busy, 0);
        check("run1_error", error, 0);

        // Run 2: restart from DONE, stall step 5, stray start during tDLLK
        clear_log();
        stall_idx  = 5;
        stall_left = 50;
        pulse_start();
        check("run2_done_cleared", done, 0);
        check("run2_busy", busy, 1);
        wait_writes(6, 200);
        repeat (25) @(negedge clk);
        check("stall_stb", wb_stb, 1);
        check("stall_cyc", wb_cyc, 1);
        check("stall_adr", wb_adr, 30'h2404);
        check("stall_dat", wb_dat_w, 32'h2);
        check("stall_no_step6", wr_adr.size(), 6);
        wait_writes(24, 2000);
        repeat (100) @(negedge clk);
        pulse_start();
        check("delay_start_busy", busy, 1);
        check("delay_start_count", wr_adr.size(), 24);
        wait_done(5000);
        check("run2_count", wr_adr.size(), 29);
        if (wr_adr.size() == 29) begin
            check("stall_len", wr_end[5] - wr_beg[5], 51);
            check("run2_tdllk", wr_beg[24] - wr_end[23], TDLLK + 1);
            check("run2_last_adr", wr_adr[28], 30'h2400);
            check("run2_last_dat", wr_dat[28], 32'h1);
        end
        stall_idx = -1;

        // Run 3: async reset during step 10, then restart from step 0
        clear_log();
        pulse_start();
        wait_writes(11, 300);
        rst_n = 1'b0;
        #1;
        check("rst_mid_cyc", wb_cyc, 0);
        check("rst_mid_stb", wb_stb, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        clear_log();
        pulse_start();
        t_start = cyc_n;
        wait_writes(1, 100);
        if (wr_adr.size() > 0) begin
            check("rerun_adr", wr_adr[0], 30'h2403);
            check("rerun_dat", wr_dat[0], 32'h0);
            check("rerun_por_latency", wr_beg[0] - t_start, POR);
        end
        wait_done(5000);
        check("rerun_count", wr_adr.size(), 29);

`ifdef DDR3_INIT_TIMEOUT_EN
        // Run 4: slave never acks; watchdog must flag an error
        begin
            int k;
            int t0;
            clear_log();
            stall_idx  = 0;
            stall_left = 1 << 30;
            pulse_start();
            wait_writes(1, 100);
            t0 = (wr_beg.size() > 0) ? wr_beg[0] : cyc_n;
            k = 0;
            while (!error && k < ACK_TO + 4) begin
                @(negedge clk);
                k++;
            end
            check("to_error", error, 1);
            check("to_cyc", wb_cyc, 0);
            check("to_latency_ok", (cyc_n - t0) <= ACK_TO + 2, 1);
            check("to_busy", busy, 0);
            check("to_done", done, 0);
            pulse_start();
            repeat (2) @(negedge clk);
            check("to_start_ignored_err", error, 1);
            check("to_start_ignored_busy", busy, 0);
            stall_idx = -1;
        end
`else
        check("error_tied_low", error, 0);
`endif

        check("bus_stable", unstable, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the bench always terminates
    initial begin
        #2000000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "global timeout");
    end

endmodule
